// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath widths and the register-dump FSM states.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        DUMP_IDLE  = 3'd0,
        DUMP_STALL = 3'd1,
        DUMP_LOAD  = 3'd2,
        DUMP_SEND  = 3'd3,
        DUMP_DONE  = 3'd4
    } dump_state_e;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Register-file dump engine: stalls the core, walks the regfile debug port and
// streams each register value with its index over a valid/ready interface.
module reg_dump_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN     = riscv_pkg::XLEN,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned SKIP_X0  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  cpu_stall,
    input  logic                  stall_ack,
    output logic [REG_ADDR_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]       dbg_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_data,
    output logic [REG_ADDR_W-1:0] out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'((SKIP_X0 != 0) ? 1 : 0);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(NUM_REGS - 1);

    dump_state_e           r_state,     w_state_nxt;
    logic [REG_ADDR_W-1:0] r_idx,       w_idx_nxt;
    logic [REG_ADDR_W-1:0] r_dbg_addr,  w_dbg_addr_nxt;
    logic [XLEN-1:0]       r_out_data,  w_out_data_nxt;
    logic [REG_ADDR_W-1:0] r_out_idx,   w_out_idx_nxt;
    logic                  r_out_last,  w_out_last_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic                  r_cpu_stall, w_cpu_stall_nxt;
    logic                  r_busy,      w_busy_nxt;
    logic                  r_done,      w_done_nxt;
    logic                  w_capture;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= DUMP_IDLE;
            r_idx       <= '0;
            r_dbg_addr  <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_cpu_stall <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_dbg_addr  <= w_dbg_addr_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_cpu_stall <= w_cpu_stall_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Next state; registered outputs are derived from the state being entered
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;

        unique case (r_state)
            DUMP_IDLE: begin
                if (start) begin
                    w_idx_nxt   = FIRST_IDX;
                    w_state_nxt = DUMP_STALL;
                end
            end
            DUMP_STALL: begin
                if (stall_ack) begin
                    w_state_nxt = DUMP_LOAD;
                end
            end
            DUMP_LOAD: begin
                w_state_nxt = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (r_out_valid && out_ready) begin
                    if (r_out_last) begin
                        w_state_nxt = DUMP_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + REG_ADDR_W'(1);
                        w_state_nxt = DUMP_LOAD;
                    end
                end
            end
            DUMP_DONE: begin
                w_state_nxt = DUMP_IDLE;
            end
            default: begin
                w_state_nxt = DUMP_IDLE;
            end
        endcase

        // Address must be on the debug port throughout LOAD, so it moves on entry
        w_dbg_addr_nxt  = (w_state_nxt == DUMP_LOAD) ? w_idx_nxt : r_dbg_addr;

        w_capture       = (r_state == DUMP_LOAD);
        w_out_data_nxt  = w_capture ? dbg_data : r_out_data;
        w_out_idx_nxt   = w_capture ? r_idx : r_out_idx;
        w_out_last_nxt  = w_capture ? (r_idx == LAST_IDX) : r_out_last;

        w_out_valid_nxt = (w_state_nxt == DUMP_SEND);
        w_cpu_stall_nxt = (w_state_nxt == DUMP_STALL) || (w_state_nxt == DUMP_LOAD) ||
                          (w_state_nxt == DUMP_SEND);
        w_busy_nxt      = (w_state_nxt != DUMP_IDLE);
        w_done_nxt      = (w_state_nxt == DUMP_DONE);
    end

    assign cpu_stall = r_cpu_stall;
    assign dbg_addr  = r_dbg_addr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Scoreboard bench for reg_dump_ctrl with a behavioural regfile debug port;
// one instance dumps from x0, a second skips x0.
module tb_reg_dump_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        stall_ack, out_ready;

    logic        stall_a, stall_b, ov_a, ov_b, last_a, last_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [4:0]  addr_a, addr_b, idx_a, idx_b;
    logic [31:0] dbg_a, dbg_b, data_a, data_b;

    logic [31:0] rf [32];

    bit          sel;
    logic        m_valid, m_last, m_stall, m_busy, m_done;
    logic [4:0]  m_idx;
    logic [31:0] m_data;

    word_t       exp_q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          done_cnt, done_cyc, words, first_cyc;

    bit          prev_hold;
    logic [31:0] prev_data;
    logic [4:0]  prev_idx;
    logic        prev_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : (32'h1000_0000 | 32'(i));
    end

    assign dbg_a = rf[addr_a];
    assign dbg_b = rf[addr_b];

    assign m_valid = sel ? ov_b     : ov_a;
    assign m_data  = sel ? data_b   : data_a;
    assign m_idx   = sel ? idx_b    : idx_a;
    assign m_last  = sel ? last_b   : last_a;
    assign m_stall = sel ? stall_b  : stall_a;
    assign m_busy  = sel ? busy_b   : busy_a;
    assign m_done  = sel ? done_b   : done_a;

    reg_dump_ctrl #(.XLEN(32), .NUM_REGS(32), .SKIP_X0(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cpu_stall(stall_a), .stall_ack(stall_ack),
        .dbg_addr(addr_a), .dbg_data(dbg_a), .out_valid(ov_a), .out_ready(out_ready),
        .out_data(data_a), .out_idx(idx_a), .out_last(last_a), .busy(busy_a), .done(done_a)
    );

    reg_dump_ctrl #(.XLEN(32), .NUM_REGS(32), .SKIP_X0(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cpu_stall(stall_b), .stall_ack(stall_ack),
        .dbg_addr(addr_b), .dbg_data(dbg_b), .out_valid(ov_b), .out_ready(out_ready),
        .out_data(data_b), .out_idx(idx_b), .out_last(last_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold-under-backpressure
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", m_data, prev_data);
                chk("hold_idx", 32'(m_idx), 32'(prev_idx));
                chk("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && first_cyc < 0) first_cyc = cyc;
            if (m_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(m_idx), 32'hFFFF_FFFF);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    chk("word_data", m_data, e.data);
                    chk("word_idx", 32'(m_idx), 32'(e.idx));
                    chk("word_last", 32'(m_last), 32'(e.last));
                    chk("word_stall", 32'(m_stall), 32'd1);
                end
                words++;
            end
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_stall_low", 32'(m_stall), 32'd0);
                chk("done_busy", 32'(m_busy), 32'd1);
            end
            prev_hold = m_valid && !out_ready;
            prev_data = m_data;
            prev_idx  = m_idx;
            prev_last = m_last;
        end
    end

    // One dump; negative idx arguments disable that feature
    task automatic run_dump(input bit use_b, input int ack_delay, input int bp_idx,
                            input int restart_idx, input int abort_idx, input int exp_done);
        int  first, bp_left, ack_cyc, start_cyc;
        bit  restarted, finished, aborted;
        first = use_b ? 1 : 0;
        for (int i = first; i < 32; i++) begin
            exp_q.push_back({((i == 0) ? 32'h0 : (32'h1000_0000 + 32'(i))), 5'(i), (i == 31)});
        end
        @(posedge clk); #1;
        sel = use_b; done_cnt = 0; words = 0; first_cyc = -1;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        stall_ack = (ack_delay == 0);
        out_ready = 1'b1;
        start_cyc = cyc;
        ack_cyc   = cyc + 1;
        bp_left = 5; restarted = 0; finished = 0; aborted = 0;
        for (int n = 1; n < 400 && !finished; n++) begin
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            if (n <= ack_delay) begin
                chk("wait_ack_stall", 32'(m_stall), 32'd1);
                chk("wait_ack_busy", 32'(m_busy), 32'd1);
                chk("wait_ack_valid", 32'(m_valid), 32'd0);
            end
            if (ack_delay != 0 && n == ack_delay + 1) begin
                stall_ack = 1'b1;
                ack_cyc = cyc;
            end
            if (restart_idx >= 0 && !restarted && m_valid && m_idx == 5'(restart_idx)) begin
                restarted = 1;
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end
            out_ready = !(bp_idx >= 0 && bp_left > 0 && m_valid && m_idx == 5'(bp_idx));
            if (!out_ready) bp_left--;
            if (abort_idx >= 0 && m_valid && m_idx == 5'(abort_idx)) begin
                rst = 1'b1; #1;
                chk("abort_valid", 32'(m_valid), 32'd0);
                chk("abort_stall", 32'(m_stall), 32'd0);
                chk("abort_busy", 32'(m_busy), 32'd0);
                chk("abort_idx_clr", 32'(m_idx), 32'd0);
                exp_q.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                chk("abort_no_done", 32'(done_cnt), 32'd0);
                chk("abort_words", 32'(words), 32'(abort_idx));
                aborted = 1;
                finished = 1;
            end
            if (done_cnt > 0) finished = 1;
        end
        if (!finished) chk("dump_timeout", 32'd0, 32'd1);
        if (!aborted) begin
            repeat (2) @(posedge clk);
            #1;
            chk("done_count", 32'(done_cnt), 32'd1);
            chk("done_latency", 32'(done_cyc - start_cyc), 32'(exp_done));
            chk("first_latency", 32'(first_cyc - ack_cyc), 32'd2);
            chk("word_count", 32'(words), 32'(32 - first));
            chk("queue_empty", 32'(exp_q.size()), 32'd0);
            chk("stall_after", 32'(m_stall), 32'd0);
            chk("busy_after", 32'(m_busy), 32'd0);
        end
        stall_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; stall_ack = 1'b0; out_ready = 1'b1;
        sel = 1'b0; done_cnt = 0; words = 0; first_cyc = -1; done_cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'({ov_a, ov_b}), 32'd0);
        chk("rst_stall", 32'({stall_a, stall_b}), 32'd0);
        chk("rst_busy", 32'({busy_a, busy_b}), 32'd0);
        chk("rst_done", 32'({done_a, done_b}), 32'd0);
        chk("rst_data", data_a | data_b, 32'd0);
        chk("rst_idx_last", 32'({idx_a, idx_b, last_a, last_b}), 32'd0);
        chk("rst_addr", 32'({addr_a, addr_b}), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", 32'({busy_a, busy_b}), 32'd0);

        run_dump(1'b0, 0, -1, -1, -1, 66);   // full dump
        run_dump(1'b1, 0, -1, -1, -1, 64);   // skip x0
        run_dump(1'b0, 10, 7, 12, -1, 81);   // delayed ack, backpressure, ignored start
        run_dump(1'b0, 0, -1, -1, 20, 0);    // reset mid-dump
        run_dump(1'b0, 0, -1, -1, -1, 66);   // fresh dump after abort

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_dump_ctrl.md
# reg_dump_ctrl

Debug read-out engine for the RV32I integer register file. On a start pulse it stalls the core, walks the register file through a dedicated combinational debug read port, and streams each 32-bit register value out on a valid/ready interface together with its index. It is the reader counterpart to the core's write-back path. It sits between the register file's debug port and the debug/UART transport.

## Interface
Parameters:
- XLEN, 32, data width of a register and of the output stream.
- NUM_REGS, 32, number of architectural registers; legal range 2..32.
- SKIP_X0, 0, when 1 the dump starts at x1 instead of x0.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin a dump; honoured only in IDLE.
- cpu_stall  out  1  freeze request to the core; held high from STALL through SEND.
- stall_ack  in  1  core is frozen; regfile contents are stable.
- dbg_addr  out  5  register index presented to the regfile debug read port.
- dbg_data  in  XLEN  combinational regfile read data for dbg_addr.
- out_valid  out  1  out_data/out_idx/out_last are valid.
- out_ready  in  1  downstream accepts the current word.
- out_data  out  XLEN  captured register value.
- out_idx  out  5  index of the register in out_data.
- out_last  out  1  marks the final word of the dump.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, STALL, LOAD, SEND, DONE.
- IDLE: on start=1, load idx = SKIP_X0 ? 1 : 0 and go to STALL. start in any other state is ignored.
- STALL: cpu_stall=1; wait for stall_ack=1, then go to LOAD. No timeout.
- LOAD: dbg_addr=idx; at the clock edge capture dbg_data into out_data, idx into out_idx, and (idx == NUM_REGS-1) into out_last; set out_valid=1; go to SEND.
- SEND: hold out_data/out_idx/out_last/out_valid stable until out_valid & out_ready at a clock edge. On that handshake clear out_valid. If out_last, go to DONE; otherwise idx = idx+1 and go to LOAD.
- DONE: done=1 for exactly one cycle; cpu_stall drops to 0 in this cycle; go to IDLE.
- out_valid never deasserts without a handshake and is never asserted outside SEND.
- dbg_addr is registered. It equals idx in LOAD and SEND and holds its last value elsewhere.
- idx is 5 bits and never wraps: the terminal compare prevents increment past NUM_REGS-1.
- If stall_ack drops mid-dump, it is ignored. The core must hold the stall while cpu_stall=1.

## Timing
- Reset: state=IDLE, idx=0, dbg_addr=0, out_data=0, out_idx=0, out_last=0, out_valid=0, cpu_stall=0, busy=0, done=0.
- rst asserted mid-dump aborts immediately. All outputs return to reset values, including out_valid=0 and cpu_stall=0; no done pulse is produced.
- Latency: start sampled at edge E0 gives STALL from E0 and cpu_stall=1 in the following cycle. If stall_ack is already high, the first out_valid appears 2 cycles after start.
- Throughput: one word per 2 cycles (LOAD+SEND) with out_ready held high. Each stalled out_ready cycle adds one cycle.
- Full dump with ack and ready always high, NUM_REGS=32, SKIP_X0=0: 1 (STALL) + 64 + 1 (DONE) = 66 cycles from start to done-high cycle.
- busy=1 from the cycle after start is accepted through the DONE cycle inclusive.

## Structure
- The shared package riscv_pkg holds:
  - XLEN and REG_ADDR_W=5.
  - The dump state enum (IDLE, STALL, LOAD, SEND, DONE).
- The block is a single module with no sub-module. The counter and FSM are too small to split.
- The regfile gains a debug read port (dbg_addr/dbg_data), an asynchronous read identical to its rs1/rs2 ports. Verification instantiates both blocks together.

## Test plan
- Full dump: preload xN=0x1000_0000+N (x0 reads 0), pulse start, hold stall_ack=1 and out_ready=1. Expect 32 words with out_idx 0..31, out_data 0, 0x1000_0001..0x1000_001F, out_last only on idx 31, done 66 cycles after start, cpu_stall low after done.
- SKIP_X0=1: same preload. Expect 31 words, first out_idx=1/out_data=0x1000_0001, and done at cycle 64.
- Backpressure: out_ready low for 5 cycles on idx 7. Expect out_valid, out_data=0x1000_0007 and out_idx=7 held stable for those cycles, and no duplicated or dropped word.
- Delayed ack: stall_ack held low for 10 cycles after start. Expect cpu_stall=1, busy=1, out_valid=0 throughout, and the first word 2 cycles after ack rises.
- Start ignored: pulse start again at idx 12. Expect the sequence unchanged and exactly one done pulse.
- Reset mid-dump: assert rst at idx 20 in SEND. Expect out_valid=0, cpu_stall=0, busy=0 immediately and no done pulse. A new start then dumps from idx 0.
